// File: rtl/arbitro_memvga.sv
// ---------------------------------------------------------------------------
// arbitro_memvga
//   Arbiter for the single-port video memory (memvga), shared between the VGA
//   scan-out reader and CPU pixel writes. VGA reads always win the port; CPU
//   writes are queued in a small FIFO and drained in cycles without a VGA
//   request (typically during blanking).
//
//   Optional build macro: ARB_STATS_EN
//     When defined, adds output stall_cnt[15:0], a saturating count of the
//     cycles in which a queued write was blocked by a VGA read.
//
// Parameters
//   AW     video memory address width
//   DW     pixel data width
//   DEPTH  CPU write FIFO entries (power of two, >= 2)
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   cpu_wr_valid  CPU write request
//   cpu_wr_ready  FIFO not full (and not in reset)
//   cpu_addr      CPU write address
//   cpu_data      CPU write data
//   vga_req       VGA read request, at most one per cycle
//   vga_addr      VGA read address
//   vga_valid     one-cycle pulse, vga_data holds the read result
//   vga_data      read data returned to the VGA reader
//   mem_addr      memory address (registered)
//   mem_wdata     memory write data (registered)
//   mem_we        memory write strobe (registered)
//   mem_re        memory read strobe (registered)
//   mem_rdata     memory read data, valid one cycle after mem_re
//   fifo_level    number of occupied FIFO entries
//   stall_cnt     blocked-write cycle count (ARB_STATS_EN only)
// ---------------------------------------------------------------------------
module arbitro_memvga #(
    parameter int AW    = 12,
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cpu_wr_valid,
    output logic                     cpu_wr_ready,
    input  logic [AW-1:0]            cpu_addr,
    input  logic [DW-1:0]            cpu_data,
    input  logic                     vga_req,
    input  logic [AW-1:0]            vga_addr,
    output logic                     vga_valid,
    output logic [DW-1:0]            vga_data,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_wdata,
    output logic                     mem_we,
    output logic                     mem_re,
    input  logic [DW-1:0]            mem_rdata,
    output logic [$clog2(DEPTH):0]   fifo_level
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]              stall_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    // One-hot encoding so each strobe is exactly one flop bit.
    typedef enum logic [1:0] {
        GRANT_NONE = 2'b00,
        GRANT_RD   = 2'b01,
        GRANT_WR   = 2'b10
    } grant_t;

    logic [AW+DW-1:0] fifo_mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    grant_t           grant_q;
    grant_t           grant_d;
    logic [AW-1:0]    addr_d;
    logic [DW-1:0]    wdata_d;

    // Set while the memory is producing data for a read issued last cycle.
    logic             rd_pend;

    assign fifo_empty   = (count == '0);
    // Ready depends only on occupancy; a pop in the same cycle does not free
    // a slot for an incoming write when the FIFO is full.
    assign cpu_wr_ready = reset && (count != FULL);
    assign push         = cpu_wr_valid && cpu_wr_ready;
    assign pop          = (grant_d == GRANT_WR);
    assign fifo_level   = count;

    assign mem_re       = (grant_q == GRANT_RD);
    assign mem_we       = (grant_q == GRANT_WR);

    // ------------------------------------------------------------------
    // Grant decision on the sampled inputs: VGA first, then queued writes.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        grant_d = GRANT_NONE;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        if (vga_req) begin
            grant_d = GRANT_RD;
            addr_d  = vga_addr;
        end else if (!fifo_empty) begin
            grant_d           = GRANT_WR;
            {addr_d, wdata_d} = fifo_mem[rd_ptr];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_q   <= GRANT_NONE;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            grant_q   <= grant_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Write FIFO: pointers wrap naturally because DEPTH is a power of two.
    // Push only when not full and pop only when not empty, so count never
    // leaves 0..DEPTH.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; the pointers and count alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {cpu_addr, cpu_data};
    end

    // ------------------------------------------------------------------
    // Read return path: mem_re -> memory registers data -> capture here.
    // Reset clears rd_pend so an interrupted read never produces vga_valid.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_pend   <= 1'b0;
            vga_valid <= 1'b0;
            vga_data  <= '0;
        end else begin
            rd_pend   <= mem_re;
            vga_valid <= rd_pend;
            if (rd_pend) vga_data <= mem_rdata;
        end
    end

`ifdef ARB_STATS_EN
    // Counts cycles where a queued write lost the port to a VGA read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (vga_req && !fifo_empty && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_arbitro_memvga.sv
// ---------------------------------------------------------------------------
// tb_arbitro_memvga
//   Directed stimulus for arbitro_memvga. Stimulus pushes the expected memory
//   writes and VGA read returns (with the cycle they must appear in) into two
//   queues; a monitor on the falling edge pops and compares whenever the DUT
//   raises mem_we or vga_valid. A small synchronous RAM model stands in for
//   memvga and is preloaded with known pixel values.
// ---------------------------------------------------------------------------
module tb_arbitro_memvga;

    localparam int AW    = 12;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            cpu_wr_valid;
    logic            cpu_wr_ready;
    logic [AW-1:0]   cpu_addr;
    logic [DW-1:0]   cpu_data;
    logic            vga_req;
    logic [AW-1:0]   vga_addr;
    logic            vga_valid;
    logic [DW-1:0]   vga_data;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_we;
    logic            mem_re;
    logic [DW-1:0]   mem_rdata;
    logic [$clog2(DEPTH):0] fifo_level;
`ifdef ARB_STATS_EN
    logic [15:0]     stall_cnt;
`endif

    always #5 clk = ~clk;

    arbitro_memvga #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_wr_valid (cpu_wr_valid),
        .cpu_wr_ready (cpu_wr_ready),
        .cpu_addr     (cpu_addr),
        .cpu_data     (cpu_data),
        .vga_req      (vga_req),
        .vga_addr     (vga_addr),
        .vga_valid    (vga_valid),
        .vga_data     (vga_data),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_re       (mem_re),
        .mem_rdata    (mem_rdata),
        .fifo_level   (fifo_level)
`ifdef ARB_STATS_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    // Edge counter: after rising edge k (and its updates) cyc == k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory model ----------------
    logic [DW-1:0] mem_model [0:(1<<AW)-1];
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [DW-1:0] load_data = '0;

    always @(posedge clk) begin
        if (load_en)     mem_model[load_addr] <= load_data;
        else if (mem_we) mem_model[mem_addr]  <= mem_wdata;
        if (mem_re)      mem_rdata <= mem_model[mem_addr];
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_exp_t;

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
    } rd_exp_t;

    wr_exp_t wq[$];
    rd_exp_t rq[$];
    wr_exp_t we_e;
    rd_exp_t re_e;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (mem_we) begin
            if (wq.size() == 0) begin
                check("unexpected_mem_we", 32'(mem_we), 32'd0);
            end else begin
                we_e = wq.pop_front();
                check("we_cycle", 32'(cyc), 32'(we_e.cyc));
                check("we_addr", 32'(mem_addr), 32'(we_e.addr));
                check("we_data", 32'(mem_wdata), 32'(we_e.data));
                check("we_re_exclusive", 32'(mem_re), 32'd0);
            end
        end
        if (vga_valid) begin
            if (rq.size() == 0) begin
                check("unexpected_vga_valid", 32'(vga_valid), 32'd0);
            end else begin
                re_e = rq.pop_front();
                check("rd_cycle", 32'(cyc), 32'(re_e.cyc));
                check("rd_data", 32'(vga_data), 32'(re_e.data));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    // Expected read return: request sampled at the next edge (cyc+1),
    // vga_valid visible after edge cyc+3.
    task automatic issue_read(input logic [AW-1:0] a, input logic [DW-1:0] d);
        vga_req  = 1'b1;
        vga_addr = a;
        rq.push_back('{cyc + 3, d});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    initial begin
        reset        = 1'b0;
        cpu_wr_valid = 1'b0;
        cpu_addr     = '0;
        cpu_data     = '0;
        vga_req      = 1'b0;
        vga_addr     = '0;

        repeat (2) tick();
        preload(12'h020, 8'h3C);
        for (int i = 0; i < 8; i++) begin
            preload(AW'(i), DW'(8'h10 + i));
            preload(AW'(12'h100 + i), DW'(8'h80 + i));
        end
        check("ready_in_reset", 32'(cpu_wr_ready), 32'd0);

        // 1. Reset release, idle outputs.
        reset = 1'b1;
        #1;
        check("t1_ready", 32'(cpu_wr_ready), 32'd1);
        check("t1_we", 32'(mem_we), 32'd0);
        check("t1_re", 32'(mem_re), 32'd0);
        check("t1_level", 32'(fifo_level), 32'd0);
        check("t1_valid", 32'(vga_valid), 32'd0);
        repeat (2) tick();

        // 2. Single write, drained one edge after it is accepted.
        cpu_wr_valid = 1'b1;
        cpu_addr     = 12'h010;
        cpu_data     = 8'hA5;
        check("t2_ready", 32'(cpu_wr_ready), 32'd1);
        wq.push_back('{cyc + 2, 12'h010, 8'hA5});
        tick();
        cpu_wr_valid = 1'b0;
        check("t2_level_after_accept", 32'(fifo_level), 32'd1);
        tick();
        check("t2_level_after_pop", 32'(fifo_level), 32'd0);
        repeat (3) tick();

        // 3. Reads hold the port; FIFO fills to 4, fifth write refused.
        for (int i = 0; i < 8; i++) begin
            issue_read(AW'(i), DW'(8'h10 + i));
            if (i < 5) begin
                check("t3_ready", 32'(cpu_wr_ready), (i < 4) ? 32'd1 : 32'd0);
                cpu_wr_valid = 1'b1;
                cpu_addr     = AW'(12'h200 + i);
                cpu_data     = DW'(8'h40 + i);
            end else begin
                cpu_wr_valid = 1'b0;
            end
            tick();
        end
        check("t3_level_full", 32'(fifo_level), 32'd4);
        check("t3_ready_full", 32'(cpu_wr_ready), 32'd0);
        vga_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wq.push_back('{cyc + 1 + k, AW'(12'h200 + k), DW'(8'h40 + k)});
        end
        repeat (5) tick();
        check("t3_level_drained", 32'(fifo_level), 32'd0);
        check("t3_ready_again", 32'(cpu_wr_ready), 32'd1);

        // 4. Single read, then eight back-to-back reads.
        issue_read(12'h020, 8'h3C);
        tick();
        vga_req = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 8; i++) begin
            issue_read(AW'(12'h100 + i), DW'(8'h80 + i));
            tick();
        end
        vga_req = 1'b0;
        repeat (4) tick();

        // 5. Reset with 3 queued writes and reads in flight: all discarded.
        for (int i = 0; i < 3; i++) begin
            vga_req      = 1'b1;
            vga_addr     = 12'h020;
            cpu_wr_valid = 1'b1;
            cpu_addr     = AW'(12'h280 + i);
            cpu_data     = DW'(i);
            tick();
        end
        check("t5_level_before", 32'(fifo_level), 32'd3);
        reset        = 1'b0;
        vga_req      = 1'b0;
        cpu_wr_valid = 1'b0;
        #1;
        check("t5_level_in_reset", 32'(fifo_level), 32'd0);
        check("t5_we_in_reset", 32'(mem_we), 32'd0);
        check("t5_re_in_reset", 32'(mem_re), 32'd0);
        check("t5_valid_in_reset", 32'(vga_valid), 32'd0);
        check("t5_ready_in_reset", 32'(cpu_wr_ready), 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (6) tick();
        check("t5_level_after", 32'(fifo_level), 32'd0);
        check("t5_ready_after", 32'(cpu_wr_ready), 32'd1);

        // 6. One queued write blocked for 10 read cycles, then drained.
        cpu_wr_valid = 1'b1;
        cpu_addr     = 12'h300;
        cpu_data     = 8'h77;
        tick();
        cpu_wr_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            issue_read(12'h020, 8'h3C);
            tick();
        end
        check("t6_level_blocked", 32'(fifo_level), 32'd1);
`ifdef ARB_STATS_EN
        check("t6_stall_cnt", 32'(stall_cnt), 32'd10);
`endif
        vga_req = 1'b0;
        wq.push_back('{cyc + 1, 12'h300, 8'h77});
        repeat (5) tick();
        check("t6_level_drained", 32'(fifo_level), 32'd0);

        repeat (3) tick();
        check("wq_empty", 32'(wq.size()), 32'd0);
        check("rq_empty", 32'(rq.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
